xor_gate_checker: RTL
=====================

# xor_gate_checker

Synthesizable response checker forming the observing end of the XOR-gate stimulus flow: a stimulus source drives operand vectors into the XOR DUT, and this block samples the same operands plus the DUT output, computes the expected result, aligns it to the DUT latency and scores every vector. It sits beside the DUT in the self-checking benches and in on-chip BIST wrappers. It reports a sticky pass/fail verdict, a saturating error count and the details of the first failure.

## Interface
- `WIDTH`, default 1: operand/result width in bits.
- `LAT`, default 0: DUT latency in clock cycles, range 0..7.
- `NUM_VEC`, default 4: vectors scored per run, minimum 1.
- `CNT_W`, default 8: width of the error counter and vector index.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle pulse that begins a run.
- `in_valid` input 1: `in_a`/`in_b` hold a vector this cycle.
- `in_a` input WIDTH: operand A driven to the DUT.
- `in_b` input WIDTH: operand B driven to the DUT.
- `dut_out` input WIDTH: DUT result.
- `busy` output 1: run in progress.
- `done` output 1: run complete; held until the next `start`.
- `pass` output 1: valid when `done`=1; 1 iff `err_count`==0.
- `err_count` output CNT_W: mismatches scored; saturates at all-ones.
- `first_err_idx` output CNT_W: index of the first failing vector, counted from 0.
- `first_err_exp` output WIDTH: expected value of the first failure.
- `first_err_got` output WIDTH: `dut_out` captured at the first failure.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: `start` moves to RUN. The same edge clears the counters, the first-error registers and the delay line.
- RUN: each `in_valid` edge accepts a vector and pushes {valid, expected = in_a ^ in_b, index} into the LAT-stage delay line. The index is the accept counter.
  - When the accept counter reaches NUM_VEC, go to DRAIN.
  - Extra `in_valid` in DRAIN or DONE is ignored.
- Scoring: when the delay-line output is valid, compare its expected value with `dut_out`.
  - On a mismatch, increment `err_count`, saturating at 2^CNT_W−1.
  - On the first mismatch only, capture the index, expected value and got value.
  - Increment the scored counter on every valid output.
- DRAIN: when the scored counter reaches NUM_VEC, go to DONE. With LAT=0, DRAIN lasts zero cycles and the FSM goes RUN→DONE on the last scoring edge.
- DONE: `done`=1. `pass` = (`err_count`==0). `start` restarts the run, clearing all state and going to RUN.
- `start` during RUN or DRAIN is ignored.
- Bubbles (`in_valid`=0) propagate through the delay line as invalid entries. They are not scored and do not advance the index.
- Width rules: the index and scored counters are CNT_W wide. NUM_VEC must be ≤ 2^CNT_W−1; a compile-time check enforces this.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_*`=0, state IDLE, delay line invalid.
- A vector accepted at edge k is scored against `dut_out` sampled at edge k+LAT. Its `err_count` update is visible after edge k+LAT.
- `done` and `pass` rise after the edge that scores vector NUM_VEC−1.
- `busy`=1 from the edge after `start` until the edge on which `done` rises.
- A `start` pulse and an `in_valid` in the same cycle from IDLE or DONE: that vector is accepted as index 0.
- If `rst_n` asserts mid-run, all outputs immediately go to their reset values and in-flight entries are discarded.

## Structure
- Package `xor_chk_pkg` holds the FSM state enum (IDLE, RUN, DRAIN, DONE) and the LAT range limit constant.
- Sub-module `xor_chk_delay` is a parameterized LAT-stage shift register of {valid, expected, index}.
  - Synchronous clear, asynchronous reset.
  - With LAT=0 it is a pass-through.
- The top level contains the FSM, counters, comparator and first-error capture.

## Test plan
- WIDTH=1, LAT=0, NUM_VEC=4, correct DUT; drive (0,0)(1,0)(0,1)(1,1) → `done` after the 4th vector, `pass`=1, `err_count`=0.
- WIDTH=1, LAT=2, DUT output stuck at 0, same vectors → `err_count`=2, `first_err_idx`=1, `first_err_exp`=1, `first_err_got`=0, `pass`=0. `done` rises 2 cycles after the last accept.
- WIDTH=4, LAT=1, bubbles interleaved with vectors A=0xF/B=0x3 and A=0x5/B=0x5 → only non-bubble vectors are scored; expected values 0xC and 0x0.
- CNT_W=2, NUM_VEC=3, DUT always wrong → `err_count` saturates at 3; `first_err_idx`=0.
- Assert `rst_n` low mid-RUN, then restart → all outputs 0 immediately; the next run scores from index 0 with no stale entries.
- `start` pulsed during RUN → ignored. `start` in DONE → counters clear and a new run begins.

Source files
------------

// File: rtl/xor_chk_pkg.sv
// Shared definitions for the XOR-gate response checker: FSM state encoding and
// the supported DUT latency range.
package xor_chk_pkg;

    localparam int unsigned LAT_MAX = 7;
    localparam int unsigned STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/xor_chk_delay.sv
// LAT-stage alignment line carrying {valid, expected, index} so each expected
// value meets the DUT output it belongs to. LAT=0 is a straight pass-through.
module xor_chk_delay #(
    parameter int unsigned DW  = 1,
    parameter int unsigned LAT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = ^{clk, rst_n, clr_i};
            assign q_o       = d_i;
        end else begin : g_pipe
            logic [DW-1:0] stage_q [LAT];

            // A clear still loads stage 0 so a vector accepted on the start edge survives.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < LAT; i++) begin
                        stage_q[i] <= '0;
                    end
                end else if (clr_i) begin
                    for (int unsigned i = 0; i < LAT; i++) begin
                        stage_q[i] <= (i == 0) ? d_i : '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int unsigned i = 1; i < LAT; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/xor_gate_checker.sv
// Scores XOR DUT responses against in_a ^ in_b aligned to the DUT latency and
// reports a sticky verdict, saturating error count and first-failure details.
module xor_gate_checker
    import xor_chk_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned LAT     = 0,
    parameter int unsigned NUM_VEC = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
);

    localparam int unsigned      DW = 1 + WIDTH + CNT_W;
    localparam logic [CNT_W-1:0] NV = CNT_W'(NUM_VEC);

    generate
        if (LAT > LAT_MAX) begin : g_bad_lat
            $error("xor_gate_checker: LAT must be in 0..7");
        end
        if ((NUM_VEC < 1) || (64'(NUM_VEC) > ((64'(1) << CNT_W) - 64'(1)))) begin : g_bad_nv
            $error("xor_gate_checker: NUM_VEC must be in 1..2**CNT_W-1");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] sc_q, sc_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic [WIDTH-1:0] fexp_q, fexp_d;
    logic [WIDTH-1:0] fgot_q, fgot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             go;
    logic             active;
    logic             push;
    logic             score;
    logic             mismatch;
    logic [CNT_W-1:0] acc_base;
    logic [DW-1:0]    dl_d;
    logic [DW-1:0]    dl_q;
    logic             dl_vld;
    logic [WIDTH-1:0] dl_exp;
    logic [CNT_W-1:0] dl_idx;

    // A start edge behaves as if all run state were already cleared.
    assign go       = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign active   = go || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign push     = in_valid && (go || (state_q == ST_RUN));
    assign acc_base = go ? '0 : acc_q;
    assign dl_d     = push ? {1'b1, in_a ^ in_b, acc_base} : '0;

    xor_chk_delay #(
        .DW  (DW),
        .LAT (LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (go),
        .d_i   (dl_d),
        .q_o   (dl_q)
    );

    assign {dl_vld, dl_exp, dl_idx} = dl_q;
    assign score    = dl_vld && active;
    assign mismatch = score && (dl_exp != dut_out);

    // Next state, counters, first-error capture and registered flags.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_base;
        sc_d    = go ? '0 : sc_q;
        err_d   = go ? '0 : err_q;
        fidx_d  = go ? '0 : fidx_q;
        fexp_d  = go ? '0 : fexp_q;
        fgot_d  = go ? '0 : fgot_q;

        if (push) begin
            acc_d = acc_d + CNT_W'(1);
        end
        if (score) begin
            sc_d = sc_d + CNT_W'(1);
        end
        if (mismatch) begin
            if (err_d == '0) begin
                fidx_d = dl_idx;
                fexp_d = dl_exp;
                fgot_d = dut_out;
            end
            if (err_d != '1) begin
                err_d = err_d + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_RUN, ST_DRAIN: begin
                if (active) begin
                    if (sc_d == NV) begin
                        state_d = ST_DONE;
                    end else if (acc_d == NV) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            sc_q    <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sc_q    <= sc_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fexp_q  <= fexp_d;
            fgot_q  <= fgot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_exp = fexp_q;
    assign first_err_got = fgot_q;

endmodule
